dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word data memory.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   m0_*/m1_* req,we,addr,wdata      requester transaction inputs (req held until ack)
//   m0_*/m1_* ack,rdata,err          one-cycle completion pulse with read data / error flag
//   mem_addr, mem_wdata, mem_w, mem_r  memory command outputs
//   mem_rdata                        memory read data
module dmem_arbiter #(
  parameter int unsigned RD_WAIT   = 4,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_w,
  output logic        mem_r,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] ADDR_MAX = AW'(MEM_BYTES - 4);
  localparam logic [CW-1:0] CNT_INIT = CW'(RD_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // next values of the registered outputs
  logic          ack_d, err_d;
  logic [DW-1:0] rdata_d;
  logic          mem_w_d, mem_r_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;

  // arbitration and request selection
  logic          gnt_c, sel_we_c, bad_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;

  // on a tie grant whoever did not win last; otherwise whoever is asking
  always_comb begin
    gnt_c       = (m0_req && m1_req) ? ~last_q : m1_req;
    sel_we_c    = gnt_c ? m1_we    : m0_we;
    sel_addr_c  = gnt_c ? m1_addr  : m0_addr;
    sel_wdata_c = gnt_c ? m1_wdata : m0_wdata;
    bad_c       = (sel_addr_c[1:0] != 2'b00) || (sel_addr_c > ADDR_MAX);
  end

  // state and context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // next state plus next values of every output, so outputs line up with the state they belong to
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;
    mem_w_d     = 1'b0;
    mem_r_d     = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d     = gnt_c;
          last_d      = gnt_c;
          we_d        = sel_we_c;
          addr_d      = sel_addr_c;
          wdata_d     = sel_wdata_c;
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = sel_wdata_c;
          if (bad_c) begin
            // illegal address: skip the memory entirely and report straight away
            state_d = DONE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_INIT;
            mem_w_d = sel_we_c;
            mem_r_d = ~sel_we_c;
          end
        end
      end
      ACCESS, WAIT: begin
        mem_addr_d  = addr_q;
        mem_wdata_d = wdata_q;
        if (we_q || (cnt_q == '0)) begin
          // last strobe cycle: capture read data into the owner's rdata register
          state_d = DONE;
          ack_d   = 1'b1;
          rdata_d = we_q ? '0 : mem_rdata;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q - CW'(1);
          mem_r_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output registers; completion is routed to the owner only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_ack    <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
      mem_w     <= 1'b0;
      mem_r     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      m0_ack    <= ack_d & ~owner_d;
      m0_err    <= err_d & ~owner_d;
      m0_rdata  <= owner_d ? '0 : rdata_d;
      m1_ack    <= ack_d & owner_d;
      m1_err    <= err_d & owner_d;
      m1_rdata  <= owner_d ? rdata_d : '0;
      mem_w     <= mem_w_d;
      mem_r     <= mem_r_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned RD_WAIT   = 4;
  localparam int unsigned MEM_BYTES = 1024;
  localparam int          BUDGET    = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err, mem_w, mem_r;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.RD_WAIT(RD_WAIT), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_r(mem_r),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // byte-wide big-endian memory attached to the DUT
  logic [7:0] env_mem [0:MEM_BYTES-1];
  bit         env_ready;
  logic [9:0] env_idx;
  assign env_idx = mem_addr[9:0];

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < MEM_BYTES; i++) env_mem[i] <= 8'h00;
      env_ready <= 1'b1;
    end else if (mem_w && mem_addr <= 32'(MEM_BYTES - 4)) begin
      env_mem[env_idx]         <= mem_wdata[31:24];
      env_mem[env_idx + 10'd1] <= mem_wdata[23:16];
      env_mem[env_idx + 10'd2] <= mem_wdata[15:8];
      env_mem[env_idx + 10'd3] <= mem_wdata[7:0];
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 32'(MEM_BYTES - 4))
      mem_rdata = {env_mem[env_idx], env_mem[env_idx + 10'd1],
                   env_mem[env_idx + 10'd2], env_mem[env_idx + 10'd3]};
  end

  // reference model: word store plus round-robin/latency rules
  logic [31:0] ref_mem [int];
  bit          ref_last = 1'b1;
  int          exp_j0, exp_j1, exp_wn, exp_rn;
  logic [31:0] exp_rd0, exp_rd1;
  bit          exp_err0, exp_err1;

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a > 32'(MEM_BYTES - 4));
  endfunction

  task automatic predict(input bit r0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit we1, input logic [31:0] a1, input logic [31:0] d1);
    bit order[$];
    int t, dur;
    bit who, we, bad;
    logic [31:0] a, d, rd;
    exp_j0 = -1; exp_j1 = -1; exp_rd0 = '0; exp_rd1 = '0;
    exp_err0 = 1'b0; exp_err1 = 1'b0; exp_wn = 0; exp_rn = 0;
    if (r0 && r1) begin
      if (ref_last) order = '{1'b0, 1'b1}; else order = '{1'b1, 1'b0};
    end else if (r0) order = '{1'b0};
    else if (r1) order = '{1'b1};
    t = 0;
    foreach (order[k]) begin
      who = order[k];
      we  = who ? we1 : we0;
      a   = who ? a1 : a0;
      d   = who ? d1 : d0;
      bad = is_bad(a);
      rd  = '0;
      if (bad) dur = 1;
      else if (we) begin dur = 2; ref_mem[int'(a)] = d; exp_wn++; end
      else begin
        dur = RD_WAIT + 1;
        exp_rn += RD_WAIT;
        if (ref_mem.exists(int'(a))) rd = ref_mem[int'(a)];
      end
      t += dur;
      if (who) begin exp_j1 = t; exp_rd1 = rd; exp_err1 = bad; end
      else     begin exp_j0 = t; exp_rd0 = rd; exp_err0 = bad; end
      t += 1;
      ref_last = who;
    end
  endtask

  // stimulus driver and recorder; j counts cycles after the sampling cycle
  int          obs_j0, obs_j1, obs_n0, obs_n1, obs_wn, obs_rn, obs_wj, obs_rj0, obs_rj1, obs_both;
  logic [31:0] obs_rd0, obs_rd1, obs_waddr, obs_wdata;
  bit          obs_err0, obs_err1, obs_timeout;

  task automatic run(input bit r0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit r1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                     input int drop0);
    int tail;
    obs_j0 = -1; obs_j1 = -1; obs_n0 = 0; obs_n1 = 0; obs_wn = 0; obs_rn = 0;
    obs_wj = -1; obs_rj0 = -1; obs_rj1 = -1; obs_both = 0;
    obs_rd0 = '0; obs_rd1 = '0; obs_err0 = 1'b0; obs_err1 = 1'b0;
    obs_waddr = '0; obs_wdata = '0; obs_timeout = 1'b1;
    tail = 0;
    m0_we = we0; m0_addr = a0; m0_wdata = d0; m0_req = r0;
    m1_we = we1; m1_addr = a1; m1_wdata = d1; m1_req = r1;
    for (int j = 1; j <= BUDGET; j++) begin
      @(negedge clk);
      if (m0_ack) begin
        obs_n0++;
        if (obs_j0 < 0) begin obs_j0 = j; obs_rd0 = m0_rdata; obs_err0 = m0_err; end
        m0_req = 1'b0;
      end
      if (m1_ack) begin
        obs_n1++;
        if (obs_j1 < 0) begin obs_j1 = j; obs_rd1 = m1_rdata; obs_err1 = m1_err; end
        m1_req = 1'b0;
      end
      if (m0_ack && m1_ack) obs_both++;
      if (mem_w) begin
        obs_wn++;
        if (obs_wj < 0) obs_wj = j;
        obs_waddr = mem_addr; obs_wdata = mem_wdata;
      end
      if (mem_r) begin
        obs_rn++;
        if (obs_rj0 < 0) obs_rj0 = j;
        obs_rj1 = j;
      end
      if (drop0 > 0 && j == drop0) m0_req = 1'b0;
      if ((!r0 || obs_n0 > 0) && (!r1 || obs_n1 > 0)) begin
        obs_timeout = 1'b0;
        tail++;
      end
      if (tail > 2) break;
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata, mem_w, mem_r, mem_addr, mem_wdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got ack=%b/%b mem_w=%b mem_r=%b mem_addr=%h want all zero",
                 m0_ack, m1_ack, mem_w, mem_r, mem_addr);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({m0_ack, m1_ack, mem_w, mem_r, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: got ack=%b/%b mem_w=%b mem_r=%b mem_addr=%h want zero",
               m0_ack, m1_ack, mem_w, mem_r, mem_addr);
    end
  endtask

  task automatic test_contention();
    predict(1, 0, 32'h40, '0, 1, 0, 32'h44, '0);
    run(1, 0, 32'h40, '0, 1, 0, 32'h44, '0, 0);
    n_tests++; if (obs_j0 !== exp_j0 || obs_j0 !== 5) begin n_fail++; $display("FAIL tie1_m0_ack_cycle: got %0d want %0d", obs_j0, exp_j0); end
    n_tests++; if (obs_j1 !== exp_j1 || obs_j1 !== 11) begin n_fail++; $display("FAIL tie1_m1_ack_cycle: got %0d want %0d", obs_j1, exp_j1); end
    n_tests++; if (obs_rn !== exp_rn) begin n_fail++; $display("FAIL tie1_mem_r_cycles: got %0d want %0d", obs_rn, exp_rn); end
    predict(1, 1, 32'h80, 32'h11111111, 1, 1, 32'h84, 32'h22222222);
    run(1, 1, 32'h80, 32'h11111111, 1, 1, 32'h84, 32'h22222222, 0);
    n_tests++; if (obs_j0 !== exp_j0 || obs_j0 !== 2) begin n_fail++; $display("FAIL tie2_m0_ack_cycle: got %0d want %0d", obs_j0, exp_j0); end
    n_tests++; if (obs_j1 !== exp_j1 || obs_j1 !== 5) begin n_fail++; $display("FAIL tie2_m1_ack_cycle: got %0d want %0d", obs_j1, exp_j1); end
    n_tests++; if (obs_both !== 0 || obs_timeout !== 1'b0) begin n_fail++; $display("FAIL tie2_ack_overlap: got both=%0d timeout=%b want 0/0", obs_both, obs_timeout); end
  endtask

  task automatic test_write();
    predict(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, '0, '0);
    run(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, '0, '0, 0);
    n_tests++; if (obs_wj !== 1 || obs_wn !== exp_wn) begin n_fail++; $display("FAIL wr_strobe: got first=%0d count=%0d want 1/%0d", obs_wj, obs_wn, exp_wn); end
    n_tests++; if (obs_waddr !== 32'h10 || obs_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_bus: got addr=%h data=%h want 00000010/deadbeef", obs_waddr, obs_wdata); end
    n_tests++; if (obs_j0 !== exp_j0) begin n_fail++; $display("FAIL wr_ack_cycle: got %0d want %0d", obs_j0, exp_j0); end
    n_tests++; if (obs_err0 !== 1'b0 || obs_rd0 !== 32'h0 || obs_n1 !== 0) begin n_fail++; $display("FAIL wr_ack_payload: got err=%b rdata=%h m1_acks=%0d want 0/0/0", obs_err0, obs_rd0, obs_n1); end
  endtask

  task automatic test_read();
    predict(0, 0, '0, '0, 1, 0, 32'h10, '0);
    run(0, 0, '0, '0, 1, 0, 32'h10, '0, 0);
    n_tests++; if (obs_rj0 !== 1 || obs_rj1 !== RD_WAIT || obs_rn !== exp_rn) begin n_fail++; $display("FAIL rd_strobe: got first=%0d last=%0d count=%0d want 1/%0d/%0d", obs_rj0, obs_rj1, obs_rn, RD_WAIT, exp_rn); end
    n_tests++; if (obs_j1 !== exp_j1) begin n_fail++; $display("FAIL rd_ack_cycle: got %0d want %0d", obs_j1, exp_j1); end
    n_tests++; if (obs_rd1 !== exp_rd1 || obs_err1 !== 1'b0) begin n_fail++; $display("FAIL rd_data: got %h err=%b want %h err=0", obs_rd1, obs_err1, exp_rd1); end
    n_tests++; if (obs_n0 !== 0 || obs_wn !== 0) begin n_fail++; $display("FAIL rd_side_effects: got m0_acks=%0d writes=%0d want 0/0", obs_n0, obs_wn); end
  endtask

  task automatic test_errors();
    predict(1, 0, 32'h13, '0, 0, 0, '0, '0);
    run(1, 0, 32'h13, '0, 0, 0, '0, '0, 0);
    n_tests++; if (obs_j0 !== exp_j0 || obs_err0 !== 1'b1 || obs_rd0 !== 32'h0) begin n_fail++; $display("FAIL err_unaligned: got cycle=%0d err=%b rdata=%h want %0d/1/0", obs_j0, obs_err0, obs_rd0, exp_j0); end
    n_tests++; if (obs_wn !== 0 || obs_rn !== 0) begin n_fail++; $display("FAIL err_unaligned_strobes: got w=%0d r=%0d want 0/0", obs_wn, obs_rn); end
    predict(0, 0, '0, '0, 1, 1, 32'h3FD, 32'hCAFEF00D);
    run(0, 0, '0, '0, 1, 1, 32'h3FD, 32'hCAFEF00D, 0);
    n_tests++; if (obs_j1 !== exp_j1 || obs_err1 !== 1'b1 || obs_rd1 !== 32'h0) begin n_fail++; $display("FAIL err_range: got cycle=%0d err=%b rdata=%h want %0d/1/0", obs_j1, obs_err1, obs_rd1, exp_j1); end
    n_tests++; if (obs_wn !== 0 || obs_rn !== 0 || obs_n0 !== 0) begin n_fail++; $display("FAIL err_range_strobes: got w=%0d r=%0d m0_acks=%0d want 0/0/0", obs_wn, obs_rn, obs_n0); end
  endtask

  task automatic test_boundary();
    predict(1, 1, 32'h3FC, 32'hA5A55A5A, 0, 0, '0, '0);
    run(1, 1, 32'h3FC, 32'hA5A55A5A, 0, 0, '0, '0, 0);
    n_tests++; if (obs_err0 !== 1'b0 || obs_wn !== 1) begin n_fail++; $display("FAIL top_word_write: got err=%b writes=%0d want 0/1", obs_err0, obs_wn); end
    predict(0, 0, '0, '0, 1, 0, 32'h3FC, '0);
    run(0, 0, '0, '0, 1, 0, 32'h3FC, '0, 0);
    n_tests++; if (obs_rd1 !== exp_rd1) begin n_fail++; $display("FAIL top_word_read: got %h want %h", obs_rd1, exp_rd1); end
    predict(1, 0, 32'h400, '0, 0, 0, '0, '0);
    run(1, 0, 32'h400, '0, 0, 0, '0, '0, 0);
    n_tests++; if (obs_err0 !== 1'b1 || obs_rn !== 0 || obs_j0 !== exp_j0) begin n_fail++; $display("FAIL past_end: got err=%b reads=%0d cycle=%0d want 1/0/%0d", obs_err0, obs_rn, obs_j0, exp_j0); end
  endtask

  task automatic test_drop();
    predict(1, 0, 32'h10, '0, 0, 0, '0, '0);
    run(1, 0, 32'h10, '0, 0, 0, '0, '0, 1);
    n_tests++; if (obs_n0 !== 1 || obs_j0 !== exp_j0) begin n_fail++; $display("FAIL drop_ack: got count=%0d cycle=%0d want 1/%0d", obs_n0, obs_j0, exp_j0); end
    n_tests++; if (obs_rd0 !== exp_rd0 || obs_rn !== exp_rn) begin n_fail++; $display("FAIL drop_data: got %h reads=%0d want %h/%0d", obs_rd0, obs_rn, exp_rd0, exp_rn); end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    m0_we = 1'b0; m0_addr = 32'h10; m0_req = 1'b1;
    repeat (3) begin @(negedge clk); if (m0_ack || m1_ack) acks++; end
    n_tests++; if (mem_r !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got mem_r=%b want 1", mem_r); end
    #2 rst_n = 1'b0;
    m0_req = 1'b0;
    #1;
    n_tests++; if (mem_r !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_async: got mem_r=%b mem_addr=%h want 0/0", mem_r, mem_addr); end
    repeat (3) begin @(negedge clk); if (m0_ack || m1_ack) acks++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (m0_ack || m1_ack) acks++; end
    n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d acks want 0", acks); end
    ref_last = 1'b1;
    predict(1, 0, 32'h10, '0, 1, 0, 32'h3FC, '0);
    run(1, 0, 32'h10, '0, 1, 0, 32'h3FC, '0, 0);
    n_tests++; if (obs_j0 !== exp_j0 || obs_j1 !== exp_j1) begin n_fail++; $display("FAIL rstmid_tiebreak: got m0=%0d m1=%0d want %0d/%0d", obs_j0, obs_j1, exp_j0, exp_j1); end
    n_tests++; if (obs_rd0 !== exp_rd0 || obs_rd1 !== exp_rd1 || obs_n0 !== 1) begin n_fail++; $display("FAIL rstmid_data: got %h/%h acks=%0d want %h/%h/1", obs_rd0, obs_rd1, obs_n0, exp_rd0, exp_rd1); end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      1:       return 32'(MEM_BYTES) + 32'($urandom_range(0, 15) * 4);
      2:       return 32'(MEM_BYTES - 4);
      default: return 32'($urandom_range(0, 15) * 4);
    endcase
  endfunction

  task automatic test_random();
    bit r0, r1, we0, we1;
    logic [31:0] a0, a1, d0, d1;
    for (int it = 0; it < 40; it++) begin
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      a0 = rand_addr(); a1 = rand_addr();
      d0 = $urandom(); d1 = $urandom();
      predict(r0, we0, a0, d0, r1, we1, a1, d1);
      run(r0, we0, a0, d0, r1, we1, a1, d1, 0);
      n_tests++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout: got no ack within %0d cycles want ack", it, BUDGET); end
      n_tests++; if (obs_j0 !== exp_j0 || obs_j1 !== exp_j1) begin n_fail++; $display("FAIL rnd%0d_ack_cycle: got %0d/%0d want %0d/%0d", it, obs_j0, obs_j1, exp_j0, exp_j1); end
      n_tests++; if (obs_n0 !== int'(r0) || obs_n1 !== int'(r1)) begin n_fail++; $display("FAIL rnd%0d_ack_count: got %0d/%0d want %0d/%0d", it, obs_n0, obs_n1, r0, r1); end
      n_tests++; if (obs_rd0 !== exp_rd0 || obs_rd1 !== exp_rd1) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h/%h want %h/%h", it, obs_rd0, obs_rd1, exp_rd0, exp_rd1); end
      n_tests++; if (obs_err0 !== exp_err0 || obs_err1 !== exp_err1) begin n_fail++; $display("FAIL rnd%0d_err: got %b/%b want %b/%b", it, obs_err0, obs_err1, exp_err0, exp_err1); end
      n_tests++; if (obs_wn !== exp_wn || obs_rn !== exp_rn) begin n_fail++; $display("FAIL rnd%0d_strobes: got w=%0d r=%0d want %0d/%0d", it, obs_wn, obs_rn, exp_wn, exp_rn); end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_write();
    test_read();
    test_errors();
    test_boundary();
    test_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test by 300000 want finish");
    $fatal(1);
  end

endmodule
